// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types and constants
package cpu_pkg;
  typedef enum logic [1:0] {FETCH, HOLD, FAULT} fetch_state_t;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;
endpackage

// File: rtl/fetch_unit_pc_next.sv
// pc_next: next-fetch target adder/mux with misalignment detect
module pc_next import cpu_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  PCsrc,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  output logic [ADDR_WIDTH-1:0] target,
  output logic                  misaligned
);
  logic [ADDR_WIDTH-1:0] w_imm;
  assign w_imm      = ImmOp[ADDR_WIDTH-1:0];
  assign target     = PCsrc ? instr_pc + w_imm : instr_pc + ADDR_WIDTH'(INSTR_BYTES);
  assign misaligned = |target[1:0];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, imem req/ack fetch, valid/ready presentation, redirect and fault trap
module fetch_unit import cpu_pkg::*; #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC),
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic [ADDR_WIDTH-1:0]  PCPlus4,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   PCsrc,
  input  logic [DATA_WIDTH-1:0]  ImmOp,
  output logic                   fault,
  output logic [ADDR_WIDTH-1:0]  fault_pc
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  fetch_state_t          r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_pc, r_instr_pc, r_fault_pc, w_target;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [CW-1:0]         r_cnt;
  logic                  w_fetch, w_take, w_xfer, w_mis, w_timeout;
  pc_next #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_pc_next (
    .instr_pc  (r_instr_pc),
    .PCsrc     (PCsrc),
    .ImmOp     (ImmOp),
    .target    (w_target),
    .misaligned(w_mis)
  );
  assign w_fetch     = r_state == FETCH;
  assign w_take      = w_fetch && imem_ack;
  assign w_xfer      = r_state == HOLD && instr_ready;
  assign w_timeout   = TIMEOUT > 0 && w_fetch && !imem_ack && r_cnt == CW'(TIMEOUT - 1);
  assign imem_req    = w_fetch && !rst;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign PCPlus4     = r_instr_pc + ADDR_WIDTH'(INSTR_BYTES);
  assign instr_valid = r_state == HOLD;
  assign fault       = r_state == FAULT;
  assign fault_pc    = r_fault_pc;
  // next state: ack wins over timeout; FAULT is only left through reset
  always_comb begin
    w_next = r_state;
    if (w_fetch) w_next = imem_ack ? HOLD : (w_timeout ? FAULT : FETCH);
    else if (w_xfer) w_next = w_mis ? FAULT : FETCH;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH;
    else r_state <= w_next;
  end
  // pc, captured instruction, wait counter and fault address
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_cnt      <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_fault_pc <= '0;
    end else begin
      r_cnt <= (w_fetch && !imem_ack) ? r_cnt + CW'(1) : '0;
      if (w_take) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= r_pc;
      end
      if (w_xfer && !w_mis) r_pc <= w_target;
      if (w_xfer && w_mis) r_fault_pc <= w_target;
      if (w_timeout) r_fault_pc <= r_pc;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a transaction-level reference model
module tb_fetch_unit;
  localparam int TO = 8;
  logic        clk = 0, rst = 1, imem_ack = 0, instr_ready = 0, PCsrc = 0;
  logic [31:0] imem_rdata = 0, ImmOp = 0;
  logic        imem_req, instr_valid, fault;
  logic [31:0] imem_addr, instr, instr_pc, PCPlus4, fault_pc;
  int checks = 0, errors = 0;

  fetch_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_pc(instr_pc), .PCPlus4(PCPlus4), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .PCsrc(PCsrc), .ImmOp(ImmOp),
    .fault(fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: an instruction is either pending presentation or the next fetch is outstanding
  logic        armed = 0, m_have = 0, m_fault = 0;
  logic [31:0] m_pc = 0, m_instr = 0, m_ipc = 0, m_fpc = 0, t;
  int          m_wait = 0;

  always @(posedge clk) begin
    armed = 1;
    if (rst) begin
      m_have = 0; m_fault = 0; m_pc = 0; m_instr = 0; m_ipc = 0; m_fpc = 0; m_wait = 0;
    end else if (!m_fault) begin
      if (!m_have) begin
        if (imem_ack) begin
          m_have = 1; m_instr = imem_rdata; m_ipc = m_pc; m_wait = 0;
        end else begin
          m_wait++;
          if (m_wait == TO) begin m_fault = 1; m_fpc = m_pc; end
        end
      end else if (instr_ready) begin
        t = PCsrc ? m_ipc + ImmOp : m_ipc + 32'd4;
        if (t % 4 != 0) begin m_fault = 1; m_fpc = t; end
        else begin m_pc = t; m_have = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("m_req", {31'b0, imem_req}, {31'b0, !rst && !m_fault && !m_have});
      if (!rst && !m_fault && !m_have) chk("m_addr", imem_addr, m_pc);
      chk("m_valid", {31'b0, instr_valid}, {31'b0, m_have && !m_fault});
      if (m_have && !m_fault) begin
        chk("m_instr", instr, m_instr);
        chk("m_ipc", instr_pc, m_ipc);
        chk("m_pc4", PCPlus4, m_ipc + 32'd4);
      end
      chk("m_fault", {31'b0, fault}, {31'b0, m_fault});
      if (m_fault) chk("m_fpc", fault_pc, m_fpc);
    end
  end

  task automatic fetch_xfer(input logic [31:0] data, input logic src, input logic [31:0] imm);
    imem_ack = 1; imem_rdata = data; instr_ready = 1; PCsrc = src; ImmOp = imm;
    @(negedge clk);
    imem_ack = 0;
    @(negedge clk);
    PCsrc = 0; ImmOp = 0;
  endtask

  task automatic reset_release();
    rst = 1; imem_ack = 0; instr_ready = 0; PCsrc = 0; ImmOp = 0;
    @(negedge clk);
    rst = 0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    rst = 0;
    #1;
    chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_valid", {31'b0, instr_valid}, 32'h0);
    chk("first_fault", {31'b0, fault}, 32'h0);
    imem_ack = 1; imem_rdata = 32'h00500093; instr_ready = 1;
    @(negedge clk);
    imem_ack = 0;
    chk("zw_instr", instr, 32'h00500093);
    chk("zw_ipc", instr_pc, 32'h0);
    chk("zw_pc4", PCPlus4, 32'h4);
    chk("zw_valid", {31'b0, instr_valid}, 32'h1);
    @(negedge clk);
    chk("zw_next", imem_addr, 32'h4);
    imem_ack = 1; imem_rdata = 32'h00000013; instr_ready = 0;
    @(negedge clk);
    imem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_instr", instr, 32'h00000013);
      chk("bp_ipc", instr_pc, 32'h4);
      chk("bp_req", {31'b0, imem_req}, 32'h0);
      imem_ack = (i == 1);
      @(negedge clk);
    end
    imem_ack = 0; instr_ready = 1;
    @(negedge clk);
    chk("bp_next", imem_addr, 32'h8);
    fetch_xfer(32'h13, 0, 0);
    fetch_xfer(32'h13, 0, 0);
    fetch_xfer(32'hFE000CE3, 1, 32'hFFFFFFF8);
    chk("br_back", imem_addr, 32'h8);
    fetch_xfer(32'h13, 1, 32'hFFFFFFF4);
    chk("br_top", imem_addr, 32'hFFFFFFFC);
    fetch_xfer(32'h13, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_fault", {31'b0, fault}, 32'h0);
    fetch_xfer(32'h13, 1, 32'h10);
    fetch_xfer(32'h0060006F, 1, 32'h6);
    chk("mis_fault", {31'b0, fault}, 32'h1);
    chk("mis_fpc", fault_pc, 32'h16);
    imem_ack = 1;
    repeat (4) begin
      chk("mis_req", {31'b0, imem_req}, 32'h0);
      @(negedge clk);
    end
    reset_release();
    chk("rst2_addr", imem_addr, 32'h0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!imem_req) break;
      n++;
      @(negedge clk);
    end
    chk("to_cycles", n, TO);
    chk("to_fault", {31'b0, fault}, 32'h1);
    chk("to_fpc", fault_pc, 32'h0);
    reset_release();
    repeat (TO - 1) @(negedge clk);
    imem_ack = 1; imem_rdata = 32'h00A00113; instr_ready = 0;
    @(negedge clk);
    imem_ack = 0;
    chk("to_ack_valid", {31'b0, instr_valid}, 32'h1);
    chk("to_ack_fault", {31'b0, fault}, 32'h0);
    chk("to_ack_instr", instr, 32'h00A00113);
    instr_ready = 1;
    @(negedge clk);
    chk("to_ack_next", imem_addr, 32'h4);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle-decode RISC-V core. It is the producer side of the instruction word that the immediate extender and control decoder consume, and the consumer of their outputs `PCsrc`/`ImmOp`. It owns the PC and issues word requests to instruction memory over a req/ack handshake. It presents each fetched instruction with valid/ready backpressure and applies taken-branch redirects. Misaligned targets and memory timeouts are trapped into a sticky fault state.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, PC and memory address width
- `INSTR_WIDTH`, 32, instruction word width
- `DATA_WIDTH`, 32, width of `ImmOp`
- `RESET_PC`, 32'h0, first fetch address after reset
- `TIMEOUT`, 255, maximum consecutive cycles `imem_req` may stay high without `imem_ack`; 0 disables the check

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `imem_req`  out  1  fetch request
- `imem_addr`  out  ADDR_WIDTH  fetch address; equals PC
- `imem_ack`  in  1  memory response valid this cycle
- `imem_rdata`  in  INSTR_WIDTH  instruction word; sampled only when `imem_ack`=1
- `instr`  out  INSTR_WIDTH  fetched instruction, to decode and sign extension
- `instr_pc`  out  ADDR_WIDTH  address of `instr`
- `PCPlus4`  out  ADDR_WIDTH  `instr_pc + 4`, for JAL/JALR writeback
- `instr_valid`  out  1  `instr` is valid
- `instr_ready`  in  1  downstream consumes `instr` this cycle
- `PCsrc`  in  1  branch/jump taken for the presented instruction
- `ImmOp`  in  DATA_WIDTH  sign-extended offset for the presented instruction
- `fault`  out  1  sticky error flag
- `fault_pc`  out  ADDR_WIDTH  offending address

## Operation
- States: FETCH, HOLD, FAULT.
- Reset: state=FETCH, pc=`RESET_PC`, timeout counter=0, `instr`=0, `instr_pc`=0, `instr_valid`=0, `fault`=0, `fault_pc`=0. While `rst`=1, `imem_req`=0.
- FETCH:
  - `imem_req`=1 and `imem_addr`=pc, both held stable until ack.
  - On `imem_ack`: capture `instr`←`imem_rdata`, `instr_pc`←pc; go to HOLD.
- HOLD:
  - `instr_valid`=1, `imem_req`=0, and `instr`/`instr_pc` are stable.
  - A transfer occurs when `instr_valid`&`instr_ready`.
  - On transfer: target = `PCsrc` ? `instr_pc` + `ImmOp`[ADDR_WIDTH-1:0] : `instr_pc` + 4.
  - If target[1:0]≠0: go to FAULT with `fault_pc`=target. Otherwise pc←target and go to FETCH.
- FAULT:
  - `fault`=1, `imem_req`=0, `instr_valid`=0.
  - Remains in FAULT until `rst`.
- Timeout:
  - The counter increments each FETCH cycle without ack and clears on ack or when leaving FETCH.
  - If `TIMEOUT`>0 and the counter reaches `TIMEOUT` with no ack, go to FAULT with `fault_pc`=pc.
- Arithmetic is modulo 2^ADDR_WIDTH; wrap-around is legal and is not a fault.
- Boundary rules:
  - `PCsrc`/`ImmOp` are ignored unless a transfer occurs that cycle.
  - `imem_ack` outside FETCH is ignored.
  - An ack arriving in the same cycle the timeout would fire is accepted; the ack wins.
  - `rst` mid-FETCH abandons the request. Memory shares `rst` and drops outstanding requests.

## Timing
- Zero-wait memory: `imem_ack` may arrive in the same cycle `imem_req` rises.
- Latency from ack to `instr_valid`: 1 cycle, since outputs are registered.
- Best-case throughput: one instruction per 2 cycles, alternating FETCH and HOLD.
- Redirect cost: none extra. The next `imem_addr` appears in the cycle after the transfer.
- The first request appears in the first cycle after `rst` deasserts.

## Structure
- Shared package `cpu_pkg` holds:
  - `fetch_state_t` enum (FETCH, HOLD, FAULT)
  - `INSTR_BYTES`=4
  - default `RESET_PC`
- Sub-module `pc_next`: combinational target adder/mux plus misalignment detect.
  - Inputs: `instr_pc`, `PCsrc`, `ImmOp`.
  - Outputs: `target`, `misaligned`.

## Test plan
- Reset: hold `rst` 2 cycles → `imem_req`=0 throughout. The next cycle gives `imem_req`=1, `imem_addr`=0x0, `instr_valid`=0, `fault`=0.
- Zero-wait fetch: ack with `imem_rdata`=0x00500093, `instr_ready`=1 → the next cycle gives `instr`=0x00500093, `instr_pc`=0x0, `PCPlus4`=0x4. The following request is at `imem_addr`=0x4.
- Backpressure: `instr_ready`=0 for 3 cycles → `instr`/`instr_pc` stable and `imem_req`=0. Raising `instr_ready` → next `imem_addr`=0x8.
- Branch:
  - `instr_pc`=0x10, `PCsrc`=1, `ImmOp`=0xFFFFFFF8 → next `imem_addr`=0x8.
  - Wrap: `instr_pc`=0xFFFFFFFC, `PCsrc`=0 → next `imem_addr`=0x0, `fault`=0.
- Misaligned target: `instr_pc`=0x10, `PCsrc`=1, `ImmOp`=0x6 → `fault`=1, `fault_pc`=0x16, `imem_req` stays 0 until `rst`.
- Timeout with `TIMEOUT`=8:
  - No ack → `imem_req` high 8 cycles, then `fault`=1 with `fault_pc`=`imem_addr`.
  - Repeat with ack on the 8th cycle → accepted, no fault.
